// File: rtl/matrix_uart_rx.sv
// matrix_uart_rx: 8N1 UART receiver feeding an ASCII matrix parser.
// A frame is "m n e00 e01 ..." as decimal tokens split by space/CR/LF;
// elements land row-major in matrixData once m and n are accepted.
module matrix_uart_rx #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 115200,
  parameter int MAX_DIM     = 5
) (
  input  logic                         clk,
  input  logic                         uartTxRstN,
  input  logic                         uartRx,
  input  logic                         abort,
  output logic [MAX_DIM*MAX_DIM*8-1:0] matrixData,
  output logic [7:0]                   m,
  output logic [7:0]                   n,
  output logic                         frameDone,
  output logic                         busy,
  output logic                         err,
  output logic [1:0]                   errCode
);
  localparam int CPB  = CLK_FREQ_HZ / BAUD_RATE;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB + 1);
  localparam int DW   = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
  localparam int NEL  = MAX_DIM * MAX_DIM;

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_st_t;
  typedef enum logic [1:0] {GET_M, GET_N, GET_ELEM} p_st_t;

  // ---------------- receiver ----------------
  logic          rx_s1, rx_s, rx_prev;
  rx_st_t        rx_st, rx_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bitn, bit_nxt;
  logic [7:0]    sh, sh_nxt;
  logic          byte_vld, ferr;

  // two-flop synchronizer plus one delayed copy for falling-edge detect
  always_ff @(posedge clk or negedge uartTxRstN) begin
    if (!uartTxRstN) begin
      rx_s1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= uartRx;
      rx_s    <= rx_s1;
      rx_prev <= rx_s;
    end
  end

  // receiver state register
  always_ff @(posedge clk or negedge uartTxRstN) begin
    if (!uartTxRstN) begin
      rx_st <= R_IDLE;
      cnt   <= '0;
      bitn  <= '0;
      sh    <= '0;
    end else begin
      rx_st <= rx_nxt;
      cnt   <= cnt_nxt;
      bitn  <= bit_nxt;
      sh    <= sh_nxt;
    end
  end

  // bit timing: start mid-point check, then one sample per bit period
  always_comb begin
    rx_nxt   = rx_st;
    cnt_nxt  = cnt + CW'(1);
    bit_nxt  = bitn;
    sh_nxt   = sh;
    byte_vld = 1'b0;
    ferr     = 1'b0;
    unique case (rx_st)
      R_IDLE: begin
        cnt_nxt = '0;
        if (rx_prev && !rx_s) rx_nxt = R_START;
      end
      R_START: if (cnt == CW'(HALF - 1)) begin
        cnt_nxt = '0;
        bit_nxt = '0;
        rx_nxt  = rx_s ? R_IDLE : R_DATA;  // high again: glitch, no error
      end
      R_DATA: if (cnt == CW'(CPB - 1)) begin
        cnt_nxt = '0;
        sh_nxt  = {rx_s, sh[7:1]};
        bit_nxt = bitn + 3'd1;
        if (bitn == 3'd7) rx_nxt = R_STOP;
      end
      R_STOP: if (cnt == CW'(CPB - 1)) begin
        cnt_nxt = '0;
        if (rx_s) begin
          byte_vld = 1'b1;
          rx_nxt   = R_IDLE;
        end else begin
          ferr   = 1'b1;
          rx_nxt = R_WAIT;  // don't take a start edge until the line recovers
        end
      end
      R_WAIT: begin
        cnt_nxt = '0;
        if (rx_s) rx_nxt = R_IDLE;
      end
      default: rx_nxt = R_IDLE;
    endcase
  end

  // ---------------- parser ----------------
  p_st_t           p_st, p_nxt;
  logic [9:0]      acc, acc_nxt;
  logic            pend, pend_nxt, ovf, ovf_nxt;
  logic [DW-1:0]   ix, ix_nxt, iy, iy_nxt;
  logic [7:0]      m_nxt, n_nxt, idx;
  logic [NEL*8-1:0] mat_nxt;
  logic            busy_nxt, done_nxt, err_nxt;
  logic [1:0]      code_nxt;
  logic [13:0]     acc_mul;
  logic            is_dig, is_del, dim_ok;

  assign is_dig  = (sh >= 8'h30) && (sh <= 8'h39);
  assign is_del  = (sh == 8'h20) || (sh == 8'h0D) || (sh == 8'h0A);
  assign acc_mul = 14'(acc) * 14'd10 + 14'(sh[3:0]);
  assign dim_ok  = (acc >= 10'd1) && (acc <= 10'(MAX_DIM));
  assign idx     = 8'(iy) * n + 8'(ix);

  // parser and output registers
  always_ff @(posedge clk or negedge uartTxRstN) begin
    if (!uartTxRstN) begin
      p_st <= GET_M;  acc <= '0;  pend <= 1'b0;  ovf <= 1'b0;
      ix <= '0;  iy <= '0;  m <= '0;  n <= '0;  matrixData <= '0;
      busy <= 1'b0;  frameDone <= 1'b0;  err <= 1'b0;  errCode <= '0;
    end else begin
      p_st <= p_nxt;  acc <= acc_nxt;  pend <= pend_nxt;  ovf <= ovf_nxt;
      ix <= ix_nxt;  iy <= iy_nxt;  m <= m_nxt;  n <= n_nxt;  matrixData <= mat_nxt;
      busy <= busy_nxt;  frameDone <= done_nxt;  err <= err_nxt;  errCode <= code_nxt;
    end
  end

  // token accumulation, commit decisions and error reporting
  always_comb begin
    p_nxt = p_st;  acc_nxt = acc;  pend_nxt = pend;  ovf_nxt = ovf;
    ix_nxt = ix;  iy_nxt = iy;  m_nxt = m;  n_nxt = n;  mat_nxt = matrixData;
    busy_nxt = busy;  done_nxt = 1'b0;  err_nxt = 1'b0;  code_nxt = errCode;
    // framing errors leave the parser untouched
    if (ferr) begin
      err_nxt  = 1'b1;
      code_nxt = 2'd0;
    end
    if (abort) begin
      p_nxt = GET_M;  acc_nxt = '0;  pend_nxt = 1'b0;  ovf_nxt = 1'b0;  busy_nxt = 1'b0;
    end else if (byte_vld) begin
      if (is_dig) begin
        acc_nxt  = acc_mul[9:0];
        ovf_nxt  = ovf | (acc_mul > 14'd255);
        pend_nxt = 1'b1;
        if (p_st == GET_M) busy_nxt = 1'b1;
      end else if (is_del) begin
        if (pend) begin
          acc_nxt = '0;  pend_nxt = 1'b0;  ovf_nxt = 1'b0;
          if (ovf) begin
            err_nxt = 1'b1;  code_nxt = 2'd2;  p_nxt = GET_M;  busy_nxt = 1'b0;
          end else begin
            unique case (p_st)
              GET_M: if (dim_ok) begin
                m_nxt = acc[7:0];  mat_nxt = '0;  busy_nxt = 1'b1;  p_nxt = GET_N;
              end else begin
                err_nxt = 1'b1;  code_nxt = 2'd3;  busy_nxt = 1'b0;
              end
              GET_N: if (dim_ok) begin
                n_nxt = acc[7:0];  ix_nxt = '0;  iy_nxt = '0;  p_nxt = GET_ELEM;
              end else begin
                err_nxt = 1'b1;  code_nxt = 2'd3;  busy_nxt = 1'b0;  p_nxt = GET_M;
              end
              GET_ELEM: begin
                for (int k = 0; k < NEL; k++)
                  if (idx == 8'(k)) mat_nxt[k*8 +: 8] = acc[7:0];
                if (8'(ix) == n - 8'd1) begin
                  ix_nxt = '0;
                  if (8'(iy) == m - 8'd1) begin
                    done_nxt = 1'b1;  busy_nxt = 1'b0;  p_nxt = GET_M;
                  end else begin
                    iy_nxt = iy + DW'(1);
                  end
                end else begin
                  ix_nxt = ix + DW'(1);
                end
              end
              default: p_nxt = GET_M;
            endcase
          end
        end
      end else begin
        acc_nxt = '0;  pend_nxt = 1'b0;  ovf_nxt = 1'b0;
        err_nxt = 1'b1;  code_nxt = 2'd1;  p_nxt = GET_M;  busy_nxt = 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_matrix_uart_rx.sv
// Bench for matrix_uart_rx: directed frames plus randomized frames, each
// compared against a token-level reference model of the matrix protocol.
`timescale 1ns/1ps
module tb_matrix_uart_rx;
  localparam int CPB = 8;

  logic         clk = 1'b0;
  logic         uartTxRstN, uartRx, abort;
  logic [199:0] matrixData;
  logic [7:0]   m, n;
  logic         frameDone, busy, err;
  logic [1:0]   errCode;

  matrix_uart_rx #(.CLK_FREQ_HZ(800_000), .BAUD_RATE(100_000), .MAX_DIM(5)) dut (
    .clk(clk), .uartTxRstN(uartTxRstN), .uartRx(uartRx), .abort(abort),
    .matrixData(matrixData), .m(m), .n(n), .frameDone(frameDone),
    .busy(busy), .err(err), .errCode(errCode)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int mon_done = 0, mon_err = 0, mon_both = 0;

  // pulse counters, sampled away from the active edge
  always @(negedge clk) begin
    if (uartTxRstN) begin
      if (frameDone) mon_done++;
      if (err) mon_err++;
      if (err && frameDone) mon_both++;
    end
  end

  initial begin
    #990_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  // ---- reference model: tokens of digits, delimiters, or junk ----
  int mst = 0, mm = 0, mn = 0, k = 0, tval = 0;
  bit tpend = 0, mbusy = 0;
  int e_done = 0, e_err = 0, e_code = 0;
  byte unsigned mat [25];

  task automatic model_err(input int code);
    e_err++;  e_code = code;  mst = 0;  mbusy = 0;
  endtask

  task automatic model_char(input byte unsigned c);
    int v;
    if (c >= 8'h30 && c <= 8'h39) begin
      if (tval <= 255) tval = tval * 10 + (c - 8'h30);
      tpend = 1;
      if (mst == 0) mbusy = 1;
    end else if (c == 8'h20 || c == 8'h0D || c == 8'h0A) begin
      if (tpend) begin
        v = tval;  tpend = 0;  tval = 0;
        if (v > 255) model_err(2);
        else if (mst == 0) begin
          if (v >= 1 && v <= 5) begin
            mm = v;  mst = 1;  mbusy = 1;
            for (int i = 0; i < 25; i++) mat[i] = 0;
          end else model_err(3);
        end else if (mst == 1) begin
          if (v >= 1 && v <= 5) begin mn = v;  k = 0;  mst = 2; end
          else model_err(3);
        end else begin
          mat[k] = 8'(v);  k++;
          if (k == mm * mn) begin e_done++;  mst = 0;  mbusy = 0; end
        end
      end
    end else begin
      tpend = 0;  tval = 0;  model_err(1);
    end
  endtask

  // ---- stimulus helpers ----
  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    uartRx = 1'b0;  repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin uartRx = b[i];  repeat (CPB) @(negedge clk); end
    uartRx = stop_ok;  repeat (CPB) @(negedge clk);
    if (!stop_ok) begin uartRx = 1'b1;  repeat (2 * CPB) @(negedge clk); end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i], 1'b1);
      model_char(s[i]);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_abort();
    abort = 1'b1;  repeat (3) @(negedge clk);  abort = 1'b0;
    mst = 0;  tval = 0;  tpend = 0;  mbusy = 0;
    repeat (2) @(negedge clk);
  endtask

  function automatic string delim();
    string d = "";
    int cnt = $urandom_range(1, 2);
    byte b;
    for (int i = 0; i < cnt; i++) begin
      case ($urandom_range(0, 2))
        0: b = 8'h20;
        1: b = 8'h0D;
        default: b = 8'h0A;
      endcase
      d = $sformatf("%s%c", d, b);
    end
    return d;
  endfunction

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [199:0] em = '0;
    for (int i = 0; i < 25; i++) em[i*8 +: 8] = mat[i];
    chk({tag, ".m"}, 200'(m), 200'(mm));
    chk({tag, ".n"}, 200'(n), 200'(mn));
    chk({tag, ".data"}, matrixData, em);
    chk({tag, ".busy"}, 200'(busy), 200'(mbusy));
    chk({tag, ".done_cnt"}, 200'(mon_done), 200'(e_done));
    chk({tag, ".err_cnt"}, 200'(mon_err), 200'(e_err));
    chk({tag, ".errCode"}, 200'(errCode), 200'(e_code));
    chk({tag, ".err_and_done"}, 200'(mon_both), 200'(0));
  endtask

  initial begin
    string s;
    int rm, rn, bad, pos;
    for (int i = 0; i < 25; i++) mat[i] = 0;
    uartTxRstN = 1'b0;  uartRx = 1'b1;  abort = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset.frameDone", 200'(frameDone), 200'(0));
    chk("reset.err", 200'(err), 200'(0));
    uartTxRstN = 1'b1;
    repeat (3) @(negedge clk);
    check_all("reset");

    send_str("2 3\n1 2 3\n4 5 255\n");
    check_all("basic");
    chk("basic.literal", matrixData, 200'h FF0504030201);

    send_str("1 1\n256 ");
    check_all("ovf");

    send_str("6 ");
    send_str("0 ");
    check_all("dim");

    send_byte(8'h41, 1'b0);
    e_err++;  e_code = 0;
    check_all("framing");
    send_str("1 1 7 ");
    check_all("after_framing");

    send_str("2 2 9 x");
    check_all("badchar");
    send_str("1 1 4\n");
    check_all("after_badchar");

    send_str("3 3 1 ");
    pulse_abort();
    check_all("abort");
    send_str("1 2 5 6\n");
    check_all("after_abort");
    chk("after_abort.literal", 200'(matrixData[15:0]), 200'h0605);

    s = "5 5 ";
    for (int e = 0; e < 25; e++) s = $sformatf("%s%0d ", s, (e * 7) % 10);
    send_str(s);
    check_all("max_dim");

    for (int f = 0; f < 8; f++) begin
      rm = $urandom_range(1, 4);
      rn = $urandom_range(1, 4);
      bad = $urandom_range(0, 5);
      pos = $urandom_range(0, rm * rn - 1);
      pulse_abort();
      if (bad == 0) s = $sformatf("%0d%s", $urandom_range(6, 9), delim());
      else s = $sformatf("%0d%s", rm, delim());
      s = $sformatf("%s%0d%s", s, rn, delim());
      for (int e = 0; e < rm * rn; e++) begin
        if (bad == 1 && e == pos) s = $sformatf("%s%0d", s, $urandom_range(256, 999));
        else s = $sformatf("%s%0d", s, $urandom_range(0, 255));
        if (bad == 2 && e == pos) s = {s, "q"};
        s = {s, delim()};
      end
      send_str(s);
      check_all($sformatf("rnd%0d", f));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
